// File: rtl/rvc_fetch_align.sv
// rtl/rvc_fetch_align.sv - prefetching RV32IC fetch unit with 16/32-bit instruction aligner
// Word reads fill a credit-limited FIFO; the aligner walks it a halfword at a time.
module rvc_fetch_align #(
  parameter int XLEN = 32,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst_data,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_is_c
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]     fifo [DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count, outstanding, drop;
  logic            half;
  logic [XLEN-1:0] fetch_addr, pc;

  logic [31:0] head_word, next_word;
  logic [15:0] head_half;
  logic        is_c, avail, req_fire, fire, pop, push;
  logic [CW:0] in_flight;

  assign head_word = fifo[rd_ptr];
  assign next_word = fifo[rd_ptr + AW'(1)];
  assign head_half = half ? head_word[31:16] : head_word[15:0];
  assign is_c      = (head_half[1:0] != 2'b11);
  // A straddling 32-bit instruction needs its upper half from the next word.
  assign avail     = (count != '0) && (is_c || !half || count >= CW'(2));

  assign inst_valid = rst && avail;
  assign inst_is_c  = inst_valid && is_c;
  assign inst_pc    = pc;

  always_comb begin
    inst_data = '0;
    if (inst_valid) begin
      if (is_c)      inst_data = {16'h0000, head_half};
      else if (half) inst_data = {next_word[15:0], head_word[31:16]};
      else           inst_data = head_word;
    end
  end

  // Responses already in flight reserve FIFO space, so the FIFO can never overflow.
  assign in_flight      = {1'b0, count} + {1'b0, outstanding};
  assign imem_req_valid = rst && !redirect_valid && (in_flight < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_addr;

  assign req_fire = imem_req_valid && imem_req_ready;
  assign fire     = inst_valid && inst_ready && !redirect_valid;
  assign pop      = fire && (half || !is_c);
  assign push     = imem_rsp_valid && (drop == '0);

  always_ff @(posedge clk) begin
    if (rst && !redirect_valid && push) fifo[wr_ptr] <= imem_rsp_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
      fetch_addr  <= RESET_PC & ~XLEN'(3);
      half        <= RESET_PC[1];
      pc          <= RESET_PC & ~XLEN'(1);
    end else if (redirect_valid) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      // Every response still owed by memory belongs to the old stream.
      outstanding <= outstanding - CW'(imem_rsp_valid);
      drop        <= outstanding - CW'(imem_rsp_valid);
      fetch_addr  <= redirect_pc & ~XLEN'(3);
      half        <= redirect_pc[1];
      pc          <= redirect_pc & ~XLEN'(1);
    end else begin
      if (req_fire) fetch_addr <= fetch_addr + XLEN'(4);
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
      if (imem_rsp_valid && drop != '0) drop <= drop - CW'(1);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
      if (fire) begin
        pc <= pc + (is_c ? XLEN'(2) : XLEN'(4));
        if (is_c) half <= ~half;
      end
    end
  end

endmodule

// File: tb/tb_rvc_fetch_align.sv
// tb/tb_rvc_fetch_align.sv - randomized scoreboard bench for rvc_fetch_align
// Expected instruction streams are derived from a halfword view of a sparse memory model.
module tb_rvc_fetch_align;

  localparam int DEPTH = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 0;
  logic        rst = 0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 0;
  logic        imem_rsp_valid = 0;
  logic [31:0] imem_rsp_data = 0;
  logic        redirect_valid = 0;
  logic [31:0] redirect_pc = 0;
  logic        inst_valid;
  logic        inst_ready = 0;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_is_c;

  rvc_fetch_align #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
    .inst_pc(inst_pc), .inst_is_c(inst_is_c)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] data; logic is_c; } exp_t;
  typedef struct { logic [31:0] data; int due; } rsp_t;

  exp_t exp_q[$];
  rsp_t rsp_q[$];
  logic [31:0] mem [logic [31:0]];

  int total = 0, bad = 0, cyc = 0, last_due = 0;
  int rdy_pct = 100, lat_min = 1, lat_max = 1, dec_pct = 100;
  bit done = 0, hs_now = 0, acc_now = 0;
  bit r1_v;
  logic [31:0] r1_a;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    logic [31:0] w;
    if (mem.exists(a)) return mem[a];
    w = a ^ 32'h5bd1_e995;
    w = w * 32'h9e37_79b1;
    w = w ^ (w >> 15);
    w = w * 32'h85eb_ca6b;
    w = w ^ (w >> 13);
    return w;
  endfunction

  function automatic logic [15:0] hw(input logic [31:0] a);
    logic [31:0] w;
    w = mem_rd({a[31:2], 2'b00});
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  // Walk the program from start: low two bits 11 mean a 32-bit instruction.
  function automatic void gen_stream(input logic [31:0] start, input int n);
    logic [31:0] p;
    logic [15:0] h;
    p = {start[31:1], 1'b0};
    for (int i = 0; i < n; i++) begin
      h = hw(p);
      if (h[1:0] != 2'b11) begin
        exp_q.push_back('{p, {16'h0000, h}, 1'b1});
        p = p + 32'd2;
      end else begin
        exp_q.push_back('{p, {hw(p + 32'd2), h}, 1'b0});
        p = p + 32'd4;
      end
    end
  endfunction

  // One clock cycle: drive inputs after the falling edge, then note what the rising edge will accept.
  task automatic step(input bit do_redir = 0, input logic [31:0] rpc = 0, input bit do_rst = 0);
    int due;
    @(negedge clk);
    cyc++;
    rst            = !do_rst;
    redirect_valid = do_redir;
    redirect_pc    = rpc;
    imem_rsp_valid = 0;
    imem_rsp_data  = 0;
    if (do_rst) begin
      rsp_q.delete();
      last_due = cyc;
    end else if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
      imem_rsp_valid = 1;
      imem_rsp_data  = rsp_q[0].data;
      void'(rsp_q.pop_front());
    end
    imem_req_ready = ($urandom_range(99) < rdy_pct);
    inst_ready     = ($urandom_range(99) < dec_pct) && (exp_q.size() > 0);
    #1;
    acc_now = imem_req_valid && imem_req_ready;
    hs_now  = rst && !redirect_valid && inst_valid && inst_ready;
    if (acc_now) begin
      due = cyc + int'($urandom_range(lat_max, lat_min));
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      rsp_q.push_back('{mem_rd(imem_req_addr), due});
    end
    if (rsp_q.size() > DEPTH) chk("credit_outstanding", 64'(rsp_q.size()), 64'(DEPTH));
  endtask

  task automatic redir(input logic [31:0] target, input int n);
    step(1, target);
    exp_q.delete();
    gen_stream(target, n);
    step();
    r1_v = imem_req_valid;
    r1_a = imem_req_addr;
    chk("redir_gap_valid", 64'(inst_valid), 64'(0));
  endtask

  task automatic drain(input string name, input int budget);
    int k = 0;
    while (exp_q.size() > 0 && k < budget) begin
      step();
      k++;
    end
    chk(name, 64'(exp_q.size()), 64'(0));
  endtask

  initial begin : monitor
    bit pv = 0;
    logic [31:0] pd, ppc;
    logic pcc;
    exp_t e;
    while (!done) begin
      @(negedge clk);
      #2;
      if (pv && rst)
        chk("hold_stable", {inst_valid, inst_is_c, inst_pc, inst_data[29:0]},
            {1'b1, pcc, ppc, pd[29:0]});
      if (rst && !redirect_valid && inst_valid && inst_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_inst", {inst_pc, inst_data}, 64'h0);
        end else begin
          e = exp_q.pop_front();
          chk("inst_pc_data", {inst_pc, inst_data}, {e.pc, e.data});
          chk("inst_is_c", 64'(inst_is_c), 64'(e.is_c));
        end
      end
      pv  = rst && !redirect_valid && inst_valid && !inst_ready;
      pd  = inst_data;
      ppc = inst_pc;
      pcc = inst_is_c;
    end
  end

  initial begin : stimulus
    int t0, first_v, hs, acc_cnt, k;
    logic [31:0] tgt;
    for (int a = 32'h100; a < 32'h200; a += 4) mem[a] = 32'h0000_0013;

    // Reset and aligned 32-bit stream from RESET_PC with zero-wait memory.
    step(0, 0, 1);
    step(0, 0, 1);
    chk("rst_req_valid", 64'(imem_req_valid), 64'(0));
    chk("rst_inst_valid", 64'(inst_valid), 64'(0));
    chk("rst_inst_pc", 64'(inst_pc), 64'(RST_PC));
    chk("rst_inst_is_c", 64'(inst_is_c), 64'(0));
    chk("rst_inst_data", 64'(inst_data), 64'(0));
    exp_q.delete();
    gen_stream(RST_PC, 12);
    step();
    t0 = cyc;
    chk("first_req", {31'(0), imem_req_valid, imem_req_addr}, {31'(0), 1'b1, RST_PC});
    first_v = -1;
    hs = 0;
    for (int i = 0; i < 13; i++) begin
      step();
      if (inst_valid && first_v < 0) first_v = cyc;
      if (first_v >= 0 && cyc < first_v + 10 && hs_now) hs++;
    end
    chk("first_valid_latency", 64'(first_v - t0), 64'(2));
    chk("aligned_throughput", 64'(hs), 64'(10));
    drain("drain_aligned", 50);

    // Two compressed instructions in one word.
    mem[32'h0] = 32'h0001_4501;
    redir(32'h0, 2);
    drain("drain_mixed", 50);

    // Compressed then a 32-bit instruction straddling the word boundary.
    mem[32'h0] = 32'h0013_4501;
    mem[32'h4] = 32'h0000_0050;
    redir(32'h0, 3);
    drain("drain_straddle", 50);

    // Redirect with three requests outstanding on a latency-4 memory.
    lat_min = 4; lat_max = 4;
    redir(32'h400, 40);
    k = 0;
    while (rsp_q.size() != 3 && k < 20) begin step(); k++; end
    chk("three_outstanding", 64'(rsp_q.size()), 64'(3));
    redir(32'h202, 20);
    chk("redir_req_next", {31'(0), r1_v, r1_a}, {31'(0), 1'b1, 32'h200});
    drain("drain_redirect", 300);

    // Backpressure: decode stalls for 20 cycles.
    lat_min = 1; lat_max = 1;
    redir(32'h800, 30);
    dec_pct = 0;
    acc_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (acc_now) acc_cnt++;
    end
    chk("stall_req_bounded", 64'(acc_cnt <= DEPTH), 64'(1));
    chk("stall_req_dropped", 64'(imem_req_valid), 64'(0));
    chk("stall_inst_valid", 64'(inst_valid), 64'(1));
    dec_pct = 100;
    drain("drain_backpressure", 200);

    // Reset while a straddling instruction waits for its second word.
    lat_min = 6; lat_max = 6;
    redir(32'h2, 4);
    step(); step(); step();
    chk("straddle_pending", 64'(inst_valid), 64'(0));
    step(0, 0, 1);
    exp_q.delete();
    gen_stream(RST_PC, 8);
    lat_min = 1; lat_max = 1;
    step();
    chk("mid_rst_inst_valid", 64'(inst_valid), 64'(0));
    chk("mid_rst_inst_pc", 64'(inst_pc), 64'(RST_PC));
    chk("mid_rst_is_c_data", {31'(0), inst_is_c, inst_data}, 64'(0));
    chk("mid_rst_req", {31'(0), imem_req_valid, imem_req_addr}, {31'(0), 1'b1, RST_PC});
    drain("drain_after_rst", 100);

    // Randomized phases, some crossing the top of the address space.
    for (int ph = 0; ph < 12; ph++) begin
      rdy_pct = int'($urandom_range(100, 40));
      lat_min = int'($urandom_range(3, 1));
      lat_max = lat_min + int'($urandom_range(3, 0));
      dec_pct = int'($urandom_range(100, 30));
      tgt = $urandom;
      if (ph % 4 == 3) tgt = 32'hffff_fff0 | (tgt & 32'hf);
      else tgt = tgt & 32'h0000_fffe | (tgt & 32'h1);
      redir(tgt, 25);
      drain("drain_random", 800);
    end

    done = 1;
    step();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
